// File: rtl/core_pkg.sv
// Shared core types: writeback sources, CSR ops, issue FSM states and
// decode-side helpers used by the issue controller.
package core_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned NumRegs  = 32;

  typedef enum logic [1:0] {WbNone, WbAlu, WbLoad, WbCsr} reg_wb_src_e;

  typedef enum logic [1:0] {OpCSRNone, OpCSRRW, OpCSRRS, OpCSRRC} csr_op_e;

  typedef enum logic [1:0] {IssRun, IssDrain, IssFlush, IssRelease} issue_state_e;

  // An instruction occupies a scoreboard slot only if it really writes a register.
  function automatic logic is_tracked(input reg_wb_src_e src, input logic [RegAddrW-1:0] rd);
    return (src != WbNone) && (rd != '0);
  endfunction

  function automatic logic is_serial(input csr_op_e op, input logic expt, input logic fencei);
    return (op != OpCSRNone) || expt || fencei;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register busy scoreboard with in-flight writeback counter.
// Hazards are derived from the registered busy vector only.
module issue_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   set_i,
  input  logic [RegAddrW-1:0]                    set_addr_i,
  input  logic                                   clr_i,
  input  logic [RegAddrW-1:0]                    clr_addr_i,
  input  logic [RegAddrW-1:0]                    rs1_addr_i,
  input  logic [RegAddrW-1:0]                    rs2_addr_i,
  input  logic [RegAddrW-1:0]                    rd_addr_i,
  input  logic                                   rd_track_i,
  output logic                                   hazard_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [NumRegs-1:0] busy_q, busy_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               set_eff, clr_hit;

  assign set_eff = set_i && (set_addr_i != '0);
  assign clr_hit = clr_i && busy_q[clr_addr_i];

  // Same-register set and clear cannot coincide: the WAW check holds off the set.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (clr_hit) busy_d[clr_addr_i] = 1'b0;
    if (set_eff) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
    case ({set_eff, clr_hit})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hazard_o      = busy_q[rs1_addr_i] | busy_q[rs2_addr_i] | (rd_track_i & busy_q[rd_addr_i]);
  assign outstanding_o = cnt_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: holds decoded instructions until hazard-free, enforces the
// writeback cap and serialization, and sequences FENCE.I drain/invalidate.
module issue_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                dec_valid_i,
  output logic                                dec_ready_o,
  input  logic [RegAddrW-1:0]                 dec_rs1_addr_i,
  input  logic [RegAddrW-1:0]                 dec_rs2_addr_i,
  input  logic [RegAddrW-1:0]                 dec_rd_addr_i,
  input  reg_wb_src_e                         dec_wb_src_i,
  input  csr_op_e                             dec_csr_op_i,
  input  logic                                dec_expt_valid_i,
  input  logic                                dec_is_fencei_i,
  output logic                                iss_valid_o,
  input  logic                                iss_ready_i,
  output logic                                iss_track_o,
  input  logic                                wb_valid_i,
  input  logic [RegAddrW-1:0]                 wb_rd_addr_i,
  input  logic                                flush_i,
  output logic                                fencei_req_o,
  input  logic                                fencei_ack_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  issue_state_e    state_q, state_d;
  logic            abort_q, abort_d;
  logic            req_q, req_d;
  logic            tracked, serial, hazard, state_ok, can_issue, xfer;
  logic [CntW-1:0] cnt;

  assign tracked = is_tracked(dec_wb_src_i, dec_rd_addr_i);
  assign serial  = is_serial(dec_csr_op_i, dec_expt_valid_i, dec_is_fencei_i);

  issue_scoreboard #(.MaxOutstanding(MaxOutstanding)) u_sb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .set_i         (xfer && tracked),
    .set_addr_i    (dec_rd_addr_i),
    .clr_i         (wb_valid_i),
    .clr_addr_i    (wb_rd_addr_i),
    .rs1_addr_i    (dec_rs1_addr_i),
    .rs2_addr_i    (dec_rs2_addr_i),
    .rd_addr_i     (dec_rd_addr_i),
    .rd_track_i    (tracked),
    .hazard_o      (hazard),
    .outstanding_o (cnt)
  );

  // FENCE.I only ever issues from Release; everything else only from Run.
  assign state_ok  = dec_is_fencei_i ? (state_q == IssRelease) : (state_q == IssRun);
  assign can_issue = !rst_i && dec_valid_i && !flush_i && !hazard && state_ok &&
                     (!tracked || (cnt < CntW'(MaxOutstanding))) &&
                     (!serial  || (cnt == '0));
  assign xfer      = can_issue && iss_ready_i;

  assign iss_valid_o   = can_issue;
  assign dec_ready_o   = xfer;
  assign iss_track_o   = can_issue && tracked;
  assign outstanding_o = cnt;
  assign fencei_req_o  = req_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IssRun;
      abort_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      req_q   <= req_d;
    end
  end

  // A flush seen while the invalidate is outstanding is remembered until the ack.
  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    case (state_q)
      IssRun: begin
        abort_d = 1'b0;
        if (dec_valid_i && dec_is_fencei_i) state_d = (cnt == '0) ? IssFlush : IssDrain;
      end
      IssDrain: begin
        if (flush_i)          state_d = IssRun;
        else if (cnt == '0)   state_d = IssFlush;
      end
      IssFlush: begin
        if (flush_i) abort_d = 1'b1;
        if (fencei_ack_i) begin
          state_d = (abort_q || flush_i) ? IssRun : IssRelease;
          abort_d = 1'b0;
        end
      end
      IssRelease: begin
        if (flush_i || xfer) state_d = IssRun;
      end
      default: state_d = IssRun;
    endcase
  end

  always_comb begin
    req_d = (state_d == IssFlush);
  end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Issue controller between the decode stage and the execute stage. It holds decoded instructions until they are safe to issue:
- RAW/WAW hazards against in-flight writebacks, tracked by a per-register busy scoreboard;
- a cap on outstanding register writebacks;
- serialization of CSR, trap-raising and FENCE.I instructions.

For FENCE.I it drains the pipeline and runs the instruction-cache invalidate handshake before letting the instruction issue.

## Interface
Parameters:
- MaxOutstanding, default 4: maximum in-flight tracked writebacks (1..31).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- dec_valid_i  in  1  decode holds a valid instruction.
- dec_ready_o  out  1  instruction accepted this cycle.
- dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i  in  5 each  register addresses from decode (unused rs = 0).
- dec_wb_src_i  in  reg_wb_src_e  writeback source; WbNone = no register write.
- dec_csr_op_i  in  csr_op_e  CSR/system op; OpCSRNone = none.
- dec_expt_valid_i  in  1  decode raised an exception.
- dec_is_fencei_i  in  1  instruction is FENCE.I.
- iss_valid_o  out  1  issue to execute.
- iss_ready_i  in  1  execute can accept.
- iss_track_o  out  1  issued instruction is tracked (wb_src != WbNone and rd != 0).
- wb_valid_i  in  1  one tracked instruction retires its register write.
- wb_rd_addr_i  in  5  retiring destination.
- flush_i  in  1  trap/redirect flush.
- fencei_req_o  out  1  I-cache invalidate request.
- fencei_ack_i  in  1  invalidate done (single-cycle pulse).
- outstanding_o  out  $clog2(MaxOutstanding+1)  tracked in-flight count.

## Operation
- **State:**
  - busy[31:0]; busy[0] is always 0.
  - outstanding counter.
  - FSM {Run, Drain, Flush, Release}.
- **hazard:** any of
  - busy[rs1];
  - busy[rs2];
  - busy[rd], only when the instruction is tracked (WAW).
  - Hazard checks use the registered busy vector only.
- **serial:** dec_csr_op_i != OpCSRNone, or dec_expt_valid_i, or dec_is_fencei_i.
- **can_issue**, all of:
  - dec_valid_i;
  - not flush_i;
  - not hazard;
  - tracked implies outstanding < MaxOutstanding;
  - serial implies outstanding == 0;
  - state == Run, except a FENCE.I may issue in Release.
- **Issue handshake:**
  - iss_valid_o = can_issue.
  - dec_ready_o = can_issue and iss_ready_i.
  - Transfer occurs when both are high.
- **On transfer of a tracked instruction:** set busy[rd] and increment outstanding.
- **On wb_valid_i:**
  - If busy[wb_rd_addr_i] is set: clear it and decrement outstanding.
  - If it is not set, or the address is 0: ignored.
- **Simultaneous set and clear:** net counter change is 0. Same-register set and clear in one cycle cannot occur, because the WAW check stalls the set.
- **Invariant:** outstanding == popcount(busy).
- **FSM transitions:**
  - Run -> Drain: dec_valid_i and dec_is_fencei_i with outstanding != 0.
  - Run -> Flush: dec_valid_i and dec_is_fencei_i with outstanding == 0. A FENCE.I never issues from Run.
  - Drain -> Flush: when outstanding == 0.
  - Flush: fencei_req_o = 1, held until fencei_ack_i; then -> Release.
  - Release: the FENCE.I issues on transfer; then -> Run.
- **flush_i:**
  - Drain or Release: -> Run.
  - Flush: the request stays high until ack, then -> Run instead of Release.
  - busy and outstanding are unaffected; in-flight writebacks still retire.

## Timing
- **Reset values:**
  - busy = 0, outstanding_o = 0, state = Run.
  - fencei_req_o = 0, iss_valid_o = 0, dec_ready_o = 0.
- **Issue** is combinational, zero added latency.
- **Retire visibility:** a wb_valid_i retire unblocks a dependent instruction in the next cycle, not the same cycle.
- **FENCE.I with an empty pipeline:**
  - Flush entered the cycle after presentation.
  - Req high from that cycle.
  - Issue no earlier than the cycle after ack.
- **fencei_req_o** is a registered FSM output, high exactly while in Flush.
- **Reset mid-handshake:** fencei_req_o drops asynchronously. The I-cache must tolerate an abandoned request.

## Structure
- issue_state_e, and the tracked/serial helper functions, go in core_pkg. They reuse reg_wb_src_e and csr_op_e.
- One sub-module, issue_scoreboard, holds busy[] and the counter, with set/clear ports and hazard outputs. The FSM and handshake stay in issue_ctrl.

## Test plan
- **Load-use RAW:** issue tracked rd=5, then an instruction with rs1=5. Required: stall (iss_valid_o=0) until wb_valid_i rd=5, and issue the following cycle.
- **Outstanding cap:** MaxOutstanding=4, issue rd=1..4 with no wb, then rd=6. Required: rd=6 stalls with outstanding_o=4; a wb of rd=2 frees it next cycle.
- **CSR serialization:** two tracked in flight, then a CSRRW. Required: the CSRRW stalls until outstanding_o=0. A CSR read with rd=0 is untracked, so outstanding stays 0.
- **FENCE.I:** with outstanding=2, present FENCE.I. Required:
  - Drain, then retire both, then fencei_req_o=1.
  - Ack after 3 cycles, then FENCE.I issues, then back in Run.
- **flush_i during Flush:** assert flush_i mid-request. Required: req held until ack, then Run with no FENCE.I issued.
- **Edge cases:**
  - rd=0 and rs=0 never stall and are never tracked.
  - Reset asserted mid-Drain returns all outputs to reset values asynchronously.
